dm_result_responder: RTL and testbench

Data-memory responder for the pipeline CPU's data port: a 64 KiB byte-addressed memory with 4-lane byte write enables and registered reads. It also detects the end-of-program store, 0xFF to byte 0xFFFC. After that store it freezes the CPU port, reads back the answer region and streams each word out over a valid/ready port with a running checksum. It sits where the bench data SRAM sits today, so silicon and FPGA runs can report results without hierarchical memory peeks.

---
 rtl/dm_result_responder_pkg.sv | 25 ++
 rtl/dm_result_responder_if.sv | 26 ++
 rtl/dm_result_responder_lane.sv | 36 +++
 rtl/dm_result_responder.sv | 145 ++++++++++++++
 tb/tb_dm_result_responder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dm_result_responder_pkg.sv
// Shared types and defaults for the data-memory result responder.
package dm_result_pkg;

  typedef enum logic [2:0] {
    RUN  = 3'd0,
    HALT = 3'd1,
    RD   = 3'd2,
    OUT  = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam int LANES = 4;
  localparam int IDX_W = 12;

  localparam logic [15:0] DEF_ANSWER_START = 16'h9000;
  localparam int          DEF_ANSWER_WORDS = 122;
  localparam logic [15:0] DEF_DONE_ADDR    = 16'hFFFC;
  localparam logic [7:0]  DEF_DONE_VALUE   = 8'hFF;

  // Running checksum step; the sum deliberately wraps at 32 bits.
  function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [31:0] word);
    return acc + word;
  endfunction

endpackage

// File: rtl/dm_result_responder_if.sv
// CPU data port plus the result-dump stream, bundled for the responder.
interface dm_result_responder_if #(
  parameter int ADDR_W = 16
) ();
  import dm_result_pkg::*;

  logic [LANES-1:0]  dm_w_en;
  logic [ADDR_W-1:0] dm_address;
  logic [31:0]       dm_w_data;
  logic [31:0]       dm_read_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [31:0]       dump_data;
  logic [IDX_W-1:0]  dump_index;
  logic              dump_last;

  modport slave (
    input  dm_w_en, dm_address, dm_w_data, dump_ready,
    output dm_read_data, dump_valid, dump_data, dump_index, dump_last
  );

  modport master (
    output dm_w_en, dm_address, dm_w_data, dump_ready,
    input  dm_read_data, dump_valid, dump_data, dump_index, dump_last
  );
endinterface

// File: rtl/dm_result_responder_lane.sv
// One byte lane of the data memory: single write enable, registered read.
module dm_byte_lane #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-3:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-3:0] raddr,
  output logic [7:0]        rdata
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);

  logic [7:0] mem_r [DEPTH];
  logic [7:0] rdata_r;

  // Array write port; contents survive reset and are preloaded externally
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read; a same-cycle write to this word is not yet visible (old data)
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= 8'h00;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;
endmodule

// File: rtl/dm_result_responder.sv
// Data-memory responder: serves the CPU data port until the done-store,
// then freezes the port and streams the answer region with a checksum.
module dm_result_responder
  import dm_result_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] ANSWER_START = ADDR_W'(DEF_ANSWER_START),
  parameter int                ANSWER_WORDS = DEF_ANSWER_WORDS,
  parameter logic [ADDR_W-1:0] DONE_ADDR    = ADDR_W'(DEF_DONE_ADDR),
  parameter logic [7:0]        DONE_VALUE   = DEF_DONE_VALUE
) (
  input  logic                  clk,
  input  logic                  rst,
  dm_result_responder_if.slave  bus,
  output logic                  halted,
  output logic                  dump_done,
  output logic [31:0]           checksum
);
  localparam int                WA_W       = ADDR_W - 2;
  localparam logic [WA_W-1:0]   START_WORD = ANSWER_START[ADDR_W-1:2];
  localparam logic [WA_W-1:0]   DONE_WORD  = DONE_ADDR[ADDR_W-1:2];
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(ANSWER_WORDS - 1);

  state_t            state_r;
  logic [IDX_W-1:0]  idx_r;
  logic              halted_r;
  logic              dump_valid_r;
  logic [IDX_W-1:0]  dump_index_r;
  logic              dump_last_r;
  logic              dump_done_r;
  logic [31:0]       checksum_r;
  logic [31:0]       frozen_r;

  logic [31:0]       lane_q_s;
  logic [WA_W-1:0]   cpu_word_s;
  logic [WA_W-1:0]   rd_word_s;
  logic [LANES-1:0]  lane_we_s;
  logic              lane_re_s;
  logic              trigger_s;
  logic              unused_s;

  assign cpu_word_s = bus.dm_address[ADDR_W-1:2];
  assign unused_s   = ^bus.dm_address[1:0];

  // Port steering: the CPU owns the array in RUN, the dump walker reads it in RD
  always_comb begin
    rd_word_s = cpu_word_s;
    lane_we_s = {LANES{1'b0}};
    lane_re_s = 1'b0;
    trigger_s = 1'b0;
    case (state_r)
      RUN: begin
        lane_we_s = bus.dm_w_en;
        lane_re_s = 1'b1;
        trigger_s = bus.dm_w_en[0] && (cpu_word_s == DONE_WORD) &&
                    (bus.dm_w_data[7:0] == DONE_VALUE);
      end
      RD: begin
        rd_word_s = START_WORD + WA_W'(idx_r);
        lane_re_s = 1'b1;
      end
      default: begin
        rd_word_s = cpu_word_s;
      end
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dm_byte_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .we    (lane_we_s[i]),
      .waddr (cpu_word_s),
      .wdata (bus.dm_w_data[8*i +: 8]),
      .re    (lane_re_s),
      .raddr (rd_word_s),
      .rdata (lane_q_s[8*i +: 8])
    );
  end

  // Control FSM together with all registered status and dump outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RUN;
      idx_r        <= 12'd0;
      halted_r     <= 1'b0;
      dump_valid_r <= 1'b0;
      dump_index_r <= 12'd0;
      dump_last_r  <= 1'b0;
      dump_done_r  <= 1'b0;
      checksum_r   <= 32'h0000_0000;
      frozen_r     <= 32'h0000_0000;
    end else begin
      case (state_r)
        RUN: begin
          if (trigger_s) begin
            state_r  <= HALT;
            halted_r <= 1'b1;
          end
        end
        HALT: begin
          // Lane registers still hold the last CPU read; keep it for the frozen port.
          frozen_r <= lane_q_s;
          state_r  <= RD;
        end
        RD: begin
          state_r      <= OUT;
          dump_valid_r <= 1'b1;
          dump_index_r <= idx_r;
          dump_last_r  <= (idx_r == LAST_IDX);
        end
        OUT: begin
          if (bus.dump_ready) begin
            dump_valid_r <= 1'b0;
            dump_last_r  <= 1'b0;
            checksum_r   <= csum_add(checksum_r, lane_q_s);
            if (idx_r == LAST_IDX) begin
              state_r     <= FIN;
              dump_done_r <= 1'b1;
            end else begin
              idx_r   <= idx_r + 12'd1;
              state_r <= RD;
            end
          end
        end
        FIN: begin
          state_r <= FIN;
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  // Lane read registers are idle outside RUN/RD, so dump_data holds during back-pressure.
  assign bus.dm_read_data = ((state_r == RUN) || (state_r == HALT)) ? lane_q_s : frozen_r;
  assign bus.dump_data    = dump_valid_r ? lane_q_s : 32'h0000_0000;
  assign bus.dump_valid   = dump_valid_r;
  assign bus.dump_index   = dump_index_r;
  assign bus.dump_last    = dump_last_r;
  assign halted           = halted_r;
  assign dump_done        = dump_done_r;
  assign checksum         = checksum_r;
endmodule

// File: tb/tb_dm_result_responder.sv
// Directed bench for dm_result_responder with a cycle-level reference model.
module tb_dm_result_responder;
  localparam int          AW      = 16;
  localparam int          NW      = 4;
  localparam logic [15:0] A_START = 16'h9000;
  localparam logic [15:0] A_DONE  = 16'hFFFC;
  localparam logic [7:0]  D_VAL   = 8'hFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        halted;
  logic        dump_done;
  logic [31:0] checksum;

  dm_result_responder_if #(.ADDR_W(AW)) bus ();

  dm_result_responder #(
    .ADDR_W(AW), .ANSWER_START(A_START), .ANSWER_WORDS(NW),
    .DONE_ADDR(A_DONE), .DONE_VALUE(D_VAL)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .halted(halted), .dump_done(dump_done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit [31:0]   mmem [int];
  bit          primed = 1'b0;
  bit          e_halted, e_valid, e_last, e_done, e_zero, e_rd_known;
  logic [31:0] e_rd, e_data, e_csum;
  int          e_index, k, next_start, ncyc = 0;
  bit [31:0]   words [$];
  bit          hs;
  int          wa;
  bit [31:0]   cur;

  // Check this cycle's outputs, then predict the next cycle from the current inputs
  always @(negedge clk) begin
    if (primed) begin
      chk32("halted", 32'(halted), 32'(e_halted));
      chk32("dump_done", 32'(dump_done), 32'(e_done));
      chk32("checksum", checksum, e_csum);
      chk32("dump_valid", 32'(bus.dump_valid), 32'(e_valid));
      if (e_valid || e_zero) begin
        chk32("dump_data", bus.dump_data, e_data);
        chk32("dump_index", 32'(bus.dump_index), 32'(e_index));
        chk32("dump_last", 32'(bus.dump_last), 32'(e_last));
      end
      if (e_rd_known) chk32("dm_read_data", bus.dm_read_data, e_rd);
    end
    hs = e_valid && bus.dump_ready;
    if (rst) begin
      e_halted = 1'b0; e_valid = 1'b0; e_last = 1'b0; e_done = 1'b0; e_zero = 1'b1;
      e_rd = 32'h0; e_rd_known = 1'b1; e_csum = 32'h0; e_index = 0; e_data = 32'h0;
      k = 0; next_start = -1; words.delete();
      primed = 1'b1;
    end else begin
      e_zero = 1'b0;
      if (!e_halted) begin
        wa = int'(bus.dm_address[15:2]);
        e_rd_known = mmem.exists(wa);
        e_rd = e_rd_known ? mmem[wa] : 32'h0;
        cur = mmem.exists(wa) ? mmem[wa] : 32'h0;
        for (int i = 0; i < 4; i++)
          if (bus.dm_w_en[i]) cur[8*i +: 8] = bus.dm_w_data[8*i +: 8];
        if (bus.dm_w_en != 4'h0) mmem[wa] = cur;
        if (bus.dm_w_en[0] && wa == int'(A_DONE[15:2]) && bus.dm_w_data[7:0] == D_VAL) begin
          e_halted = 1'b1;
          next_start = ncyc + 3;
          for (int i = 0; i < NW; i++) begin
            wa = (int'(A_START[15:2]) + i) % 16384;
            words.push_back(mmem.exists(wa) ? mmem[wa] : 32'h0);
          end
        end
      end
      if (hs) begin
        e_csum = e_csum + e_data;
        k++;
        e_valid = 1'b0;
        if (k == NW) e_done = 1'b1;
        else next_start = ncyc + 2;
      end else if (e_halted && !e_done && next_start >= 0 && ncyc + 1 >= next_start) begin
        e_valid = 1'b1;
        e_index = k;
        e_data  = words[k];
        e_last  = (k == NW - 1);
      end
    end
    ncyc++;
  end

  // Record every accepted word for the literal end-of-dump checks
  logic [31:0] cap_d [$];
  bit          cap_l [$];
  always @(negedge clk) begin
    if (!rst && bus.dump_valid && bus.dump_ready) begin
      cap_d.push_back(bus.dump_data);
      cap_l.push_back(bus.dump_last);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [3:0] en, input logic [31:0] d);
    bus.dm_address = a; bus.dm_w_en = en; bus.dm_w_data = d;
    step();
    bus.dm_w_en = 4'h0;
  endtask

  task automatic rd(input logic [15:0] a);
    bus.dm_address = a; bus.dm_w_en = 4'h0;
    step();
  endtask

  logic [31:0] exp4 [4];

  initial begin
    exp4[0] = 32'd1; exp4[1] = 32'd2; exp4[2] = 32'd3; exp4[3] = 32'd4;
    rst = 1'b1;
    bus.dm_address = 16'h0000; bus.dm_w_en = 4'h0; bus.dm_w_data = 32'h0; bus.dump_ready = 1'b0;
    step(); step();
    chk32("rst_read_data", bus.dm_read_data, 32'h0);
    chk32("rst_checksum", checksum, 32'h0);
    rst = 1'b0;

    // Clear the words the bench later reads back
    wr(16'h0000, 4'hF, 32'h0); wr(16'h0100, 4'hF, 32'h0);
    wr(16'h0200, 4'hF, 32'h0); wr(A_DONE, 4'hF, 32'h0);

    // Byte-lane write then read
    wr(16'h0100, 4'b0101, 32'hAABBCCDD);
    rd(16'h0100);
    chk32("lane_rw", bus.dm_read_data, 32'h00BB00DD);

    // Read-before-write in the same cycle
    wr(16'h0200, 4'hF, 32'h11111111);
    wr(16'h0200, 4'hF, 32'h22222222);
    chk32("rbw_old", bus.dm_read_data, 32'h11111111);
    rd(16'h0200);
    chk32("rbw_new", bus.dm_read_data, 32'h22222222);

    // Answer region 1,2,3,4
    for (int i = 0; i < NW; i++) wr(A_START + 16'(4*i), 4'hF, 32'(i + 1));

    // Non-trigger store, then the real done-store
    wr(A_DONE, 4'b0001, 32'h000000FE);
    chk32("fe_no_halt", 32'(halted), 32'd0);
    rd(A_DONE);
    chk32("fe_stored", bus.dm_read_data, 32'h000000FE);
    wr(A_DONE, 4'b0001, 32'h000000FF);
    chk32("ff_halt", 32'(halted), 32'd1);
    wr(16'h0000, 4'hF, 32'hDEADBEEF);

    // Dump with ready toggling every cycle
    cap_d.delete(); cap_l.delete();
    for (int i = 0; i < 60 && !dump_done; i++) begin
      bus.dump_ready = ~bus.dump_ready;
      step();
    end
    chk32("bp_done", 32'(dump_done), 32'd1);
    chk32("bp_count", 32'(cap_d.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < cap_d.size()) begin
        chk32("bp_word", cap_d[i], exp4[i]);
        chk32("bp_last", 32'(cap_l[i]), (i == 3) ? 32'd1 : 32'd0);
      end
    end
    chk32("bp_checksum", checksum, 32'd10);
    bus.dump_ready = 1'b0;

    // Post-halt CPU write must not have landed
    rst = 1'b1; step(); rst = 1'b0;
    rd(16'h0000);
    chk32("halt_drop", bus.dm_read_data, 32'h0);

    // Wrap-around checksum, ready held high
    wr(A_START, 4'hF, 32'hFFFFFFFF); wr(A_START + 16'd4, 4'hF, 32'h00000002);
    wr(A_START + 16'd8, 4'hF, 32'h0); wr(A_START + 16'd12, 4'hF, 32'h0);
    bus.dump_ready = 1'b1;
    wr(A_DONE, 4'hF, 32'h000000FF);
    chk32("wr_halt", 32'(halted), 32'd1);
    chk32("wr_not_yet", 32'(bus.dump_valid), 32'd0);
    step(); step();
    chk32("wr_first_valid", 32'(bus.dump_valid), 32'd1);
    chk32("wr_first_data", bus.dump_data, 32'hFFFFFFFF);
    for (int i = 0; i < 20 && !dump_done; i++) step();
    chk32("wr_done", 32'(dump_done), 32'd1);
    chk32("wr_checksum", checksum, 32'h00000001);

    // Reset in the middle of the dump
    rst = 1'b1; step(); rst = 1'b0;
    wr(A_DONE, 4'hF, 32'h000000FF);
    for (int i = 0; i < 20 && !bus.dump_valid; i++) step();
    chk32("md_valid0", 32'(bus.dump_valid), 32'd1);
    step();
    bus.dump_ready = 1'b0;
    step();
    chk32("md_index1", 32'(bus.dump_index), 32'd1);
    chk32("md_valid1", 32'(bus.dump_valid), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk32("md_valid_drop", 32'(bus.dump_valid), 32'd0);
    chk32("md_checksum", checksum, 32'h0);
    chk32("md_halted", 32'(halted), 32'd0);
    rd(A_START);
    chk32("md_mem_kept", bus.dm_read_data, 32'hFFFFFFFF);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
